// File: rtl/decode_stage.sv
// Decode stage: holds one instruction in D, forwards it to the ID/EX slot X,
// and stalls on load-use hazards and for the duration of a multi-cycle mul/div.
module decode_stage #(
  parameter int PC_W         = 12,
  parameter int MD_LATENCY   = 32,
  parameter bit R0_NO_HAZARD = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      read_reg_s1,
  output logic [4:0]      read_reg_s2,
  output logic            out_valid,
  output logic [31:0]     out_instruction,
  output logic [PC_W-1:0] out_pc,
  output logic            stall
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dValid_q, dValid_d;
  logic [31:0]       dInstr_q, dInstr_d;
  logic [PC_W-1:0]   dPc_q, dPc_d;
  logic              xValid_q, xValid_d;
  logic [31:0]       xInstr_q, xInstr_d;
  logic [PC_W-1:0]   xPc_q, xPc_d;

  logic [4:0] dOp, dAluOp, xOp, xRd;
  logic       useRdAsS2, hazard, mulDiv, readyRun;

  assign dOp    = dInstr_q[31:27];
  assign dAluOp = dInstr_q[6:2];
  assign xOp    = xInstr_q[31:27];
  assign xRd    = xInstr_q[26:22];

  // Store/branch-style opcodes read their second operand from the rd field.
  always_comb begin
    useRdAsS2 = 1'b0;
    case (dOp)
      5'b00010, 5'b00100, 5'b00101, 5'b00110, 5'b00111: useRdAsS2 = 1'b1;
      default: useRdAsS2 = 1'b0;
    endcase
  end

  assign read_reg_s1 = dInstr_q[21:17];
  assign read_reg_s2 = useRdAsS2 ? dInstr_q[26:22] : dInstr_q[16:12];

  assign hazard = dValid_q && xValid_q && (xOp == 5'b01000) &&
                  ((xRd == read_reg_s1) || (xRd == read_reg_s2)) &&
                  !(R0_NO_HAZARD && (xRd == 5'd0));

  assign mulDiv = dValid_q && (dOp == 5'b00000) &&
                  ((dAluOp == 5'b00110) || (dAluOp == 5'b00111));

  // Priority: flush, then an outstanding mul/div, then hazard, then advance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dValid_d = dValid_q;
    dInstr_d = dInstr_q;
    dPc_d    = dPc_q;
    xValid_d = xValid_q;
    xInstr_d = xInstr_q;
    xPc_d    = xPc_q;
    readyRun = 1'b0;
    if (flush) begin
      dValid_d = 1'b0;
      xValid_d = 1'b0;
      state_d  = RUN;
      cnt_d    = '0;
    end else if (state_q == MD_WAIT) begin
      xValid_d = 1'b0;
      if (cnt_q == '0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (hazard) begin
      xValid_d = 1'b0;
    end else begin
      readyRun = 1'b1;
      xValid_d = dValid_q;
      xInstr_d = dInstr_q;
      xPc_d    = dPc_q;
      dValid_d = in_valid;
      if (in_valid) begin
        dInstr_d = instruction;
        dPc_d    = in_pc;
      end
      if (mulDiv) begin
        state_d = MD_WAIT;
        cnt_d   = MD_LOAD;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      dValid_q <= 1'b0;
      dInstr_q <= '0;
      dPc_q    <= '0;
      xValid_q <= 1'b0;
      xInstr_q <= '0;
      xPc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dValid_q <= dValid_d;
      dInstr_q <= dInstr_d;
      dPc_q    <= dPc_d;
      xValid_q <= xValid_d;
      xInstr_q <= xInstr_d;
      xPc_q    <= xPc_d;
    end
  end

  // Ready is forced high while reset is held so fetch sees an idle stage.
  assign in_ready        = reset || readyRun;
  assign stall           = ~in_ready;
  assign out_valid       = xValid_q;
  assign out_instruction = xInstr_q;
  assign out_pc          = xPc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a cycle table for hazards/operand select,
// plus hand sequences for streaming, mul/div wait, flush and async reset.
module tb_decode_stage;

  localparam int PC_W = 12;
  localparam int MDL  = 4;

  logic            clock, reset, in_valid, in_ready, flush, out_valid, stall;
  logic [31:0]     instruction, out_instruction;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [4:0]      read_reg_s1, read_reg_s2;

  int assertions = 0;
  int failures   = 0;

  decode_stage #(.PC_W(PC_W), .MD_LATENCY(MDL), .R0_NO_HAZARD(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .flush(flush),
    .read_reg_s1(read_reg_s1), .read_reg_s2(read_reg_s2),
    .out_valid(out_valid), .out_instruction(out_instruction),
    .out_pc(out_pc), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic            v;
    logic [31:0]     ins;
    logic [PC_W-1:0] pc;
    logic            rdy;
    logic [4:0]      s1;
    logic [4:0]      s2;
    logic            ov;
    logic            chk;
    logic [31:0]     oi;
    logic [PC_W-1:0] opc;
  } vec_t;

  localparam logic [31:0] LW3 = 32'h40C20000;
  localparam logic [31:0] ADD = 32'h01062000;
  localparam logic [31:0] LW0 = 32'h40020000;
  localparam logic [31:0] BR0 = 32'h10000000;
  localparam logic [31:0] LW5 = 32'h41440000;
  localparam logic [31:0] SW5 = 32'h21409000;
  localparam logic [31:0] OP3 = 32'h19409000;
  localparam logic [31:0] MUL = 32'h014C7018;

  function automatic logic [31:0] mk(input int k);
    mk = {5'b00000, 5'(k + 1), 5'(k + 9), 5'(k + 17), 12'h004};
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic [PC_W-1:0] pc, input logic fl);
    @(negedge clock);
    in_valid    = v;
    instruction = ins;
    in_pc       = pc;
    flush       = fl;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " stall"}, 32'(stall), 32'd0);
    checkOutput({tag, " s1"}, 32'(read_reg_s1), 32'd0);
    checkOutput({tag, " s2"}, 32'(read_reg_s2), 32'd0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " out_instr"}, out_instruction, 32'd0);
    checkOutput({tag, " out_pc"}, 32'(out_pc), 32'd0);
  endtask

  vec_t tbl[12];
  int   busy;

  initial begin
    tbl[0]  = '{1'b1, LW3, 12'h010, 1'b1, 5'd1 - 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 12'h000};
    tbl[1]  = '{1'b1, ADD, 12'h014, 1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 12'h000};
    tbl[2]  = '{1'b1, LW0, 12'h018, 1'b0, 5'd3, 5'd2, 1'b1, 1'b1, LW3, 12'h010};
    tbl[3]  = '{1'b1, LW0, 12'h018, 1'b1, 5'd3, 5'd2, 1'b0, 1'b1, LW3, 12'h010};
    tbl[4]  = '{1'b1, BR0, 12'h01C, 1'b1, 5'd1, 5'd0, 1'b1, 1'b1, ADD, 12'h014};
    tbl[5]  = '{1'b1, LW5, 12'h020, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, LW0, 12'h018};
    tbl[6]  = '{1'b1, SW5, 12'h024, 1'b1, 5'd2, 5'd0, 1'b1, 1'b1, BR0, 12'h01C};
    tbl[7]  = '{1'b1, OP3, 12'h028, 1'b0, 5'd0, 5'd5, 1'b1, 1'b1, LW5, 12'h020};
    tbl[8]  = '{1'b1, OP3, 12'h028, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, LW5, 12'h020};
    tbl[9]  = '{1'b0, 32'h0, 12'h000, 1'b1, 5'd0, 5'd9, 1'b1, 1'b1, SW5, 12'h024};
    tbl[10] = '{1'b0, 32'h0, 12'h000, 1'b1, 5'd0, 5'd9, 1'b1, 1'b1, OP3, 12'h028};
    tbl[11] = '{1'b0, 32'h0, 12'h000, 1'b1, 5'd0, 5'd9, 1'b0, 1'b0, 32'h0, 12'h000};

    reset = 1'b1; in_valid = 1'b0; instruction = '0; in_pc = '0; flush = 1'b0;
    #3;
    checkResetOutputs("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].v, tbl[i].ins, tbl[i].pc, 1'b0);
      checkOutput($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      checkOutput($sformatf("row%0d stall", i), 32'(stall), 32'(!tbl[i].rdy));
      checkOutput($sformatf("row%0d s1", i), 32'(read_reg_s1), 32'(tbl[i].s1));
      checkOutput($sformatf("row%0d s2", i), 32'(read_reg_s2), 32'(tbl[i].s2));
      checkOutput($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].chk) begin
        checkOutput($sformatf("row%0d out_instr", i), out_instruction, tbl[i].oi);
        checkOutput($sformatf("row%0d out_pc", i), 32'(out_pc), 32'(tbl[i].opc));
      end
    end

    for (int k = 0; k < 10; k++) begin
      applyStimulus(k < 8, mk(k), 12'(12'h100 + 4 * k), 1'b0);
      checkOutput($sformatf("stream%0d in_ready", k), 32'(in_ready), 32'd1);
      if (k >= 2) begin
        checkOutput($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
        checkOutput($sformatf("stream%0d out_instr", k), out_instruction, mk(k - 2));
        checkOutput($sformatf("stream%0d out_pc", k), 32'(out_pc),
                    32'(12'h100 + 4 * (k - 2)));
      end
    end

    applyStimulus(1'b1, MUL, 12'h200, 1'b0);
    checkOutput("mul accept in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, mk(20), 12'h204, 1'b0);
    checkOutput("mul issue in_ready", 32'(in_ready), 32'd1);
    checkOutput("mul s1", 32'(read_reg_s1), 32'd6);
    checkOutput("mul s2", 32'(read_reg_s2), 32'd7);
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 32'h0, 12'h000, 1'b0);
      if (in_ready !== 1'b0) break;
      busy++;
      if (c == 0) begin
        checkOutput("mul out_valid first", 32'(out_valid), 32'd1);
        checkOutput("mul out_instr", out_instruction, MUL);
      end else begin
        checkOutput($sformatf("mul wait%0d out_valid", c), 32'(out_valid), 32'd0);
      end
    end
    checkOutput("mul busy cycles", 32'(busy), 32'(MDL));
    checkOutput("mul resume out_valid", 32'(out_valid), 32'd0);
    checkOutput("mul resume s1", 32'(read_reg_s1), 32'd29);
    applyStimulus(1'b0, 32'h0, 12'h000, 1'b0);
    checkOutput("mul next out_valid", 32'(out_valid), 32'd1);
    checkOutput("mul next out_instr", out_instruction, mk(20));

    applyStimulus(1'b1, MUL, 12'h300, 1'b0);
    applyStimulus(1'b1, mk(21), 12'h304, 1'b0);
    applyStimulus(1'b0, 32'h0, 12'h000, 1'b0);
    checkOutput("flush wait3 in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 32'h0, 12'h000, 1'b1);
    checkOutput("flush wait2 in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush wait2 stall", 32'(stall), 32'd1);
    applyStimulus(1'b0, 32'h0, 12'h000, 1'b0);
    checkOutput("flush after in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush after out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 12'h000, 1'b0);
    checkOutput("flush killed D", 32'(out_valid), 32'd0);

    applyStimulus(1'b1, LW3, 12'h400, 1'b0);
    applyStimulus(1'b1, ADD, 12'h404, 1'b0);
    applyStimulus(1'b1, mk(5), 12'h408, 1'b0);
    checkOutput("prereset stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkResetOutputs("async reset");
    @(negedge clock);
    reset       = 1'b0;
    in_valid    = 1'b1;
    instruction = mk(6);
    in_pc       = 12'h40C;
    #1;
    checkOutput("post reset in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 32'h0, 12'h000, 1'b0);
    checkOutput("post reset s1", 32'(read_reg_s1), 32'd15);
    checkOutput("post reset out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 12'h000, 1'b0);
    checkOutput("post reset X valid", 32'(out_valid), 32'd1);
    checkOutput("post reset X instr", out_instruction, mk(6));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
